// File: rtl/memory_n_to_1_arbiter_if.sv
// Request/response bundle between N requesting channels and the shared-memory arbiter.
// Latency: none (wires only).
// Backpressure: req_ready is the one-hot grant; a channel holds its request until granted.
//
// Ports (signals):
//   req_valid/req_we  per-channel request valid and write enable
//   req_addr/req_din  per-channel local address and write data, channel i in slice i
//   req_ready         one-hot grant back to the channels
//   rd_valid/rd_ch/rd_data  tagged read response
//   err_oob           one-cycle out-of-window pulse
interface memory_n_to_1_arbiter_if #(
  parameter int WIDTH        = 32,
  parameter int NUM_CH       = 4,
  parameter int CH_DEPTH_LOG = 4,
  parameter int CH_LOG       = 2
);
  logic [NUM_CH-1:0]              req_valid;
  logic [NUM_CH-1:0]              req_we;
  logic [NUM_CH*CH_DEPTH_LOG-1:0] req_addr;
  logic [NUM_CH*WIDTH-1:0]        req_din;
  logic [NUM_CH-1:0]              req_ready;
  logic                           rd_valid;
  logic [CH_LOG-1:0]              rd_ch;
  logic [WIDTH-1:0]               rd_data;
  logic                           err_oob;

  // Requester side.
  modport master (
    output req_valid, req_we, req_addr, req_din,
    input  req_ready, rd_valid, rd_ch, rd_data, err_oob
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_we, req_addr, req_din,
    output req_ready, rd_valid, rd_ch, rd_data, err_oob
  );
endinterface

// File: rtl/memory_n_to_1_arbiter.sv
// N-channel arbiter in front of one shared single-port memory, each channel in a private window.
// Latency: grant 0 cycles, read data 1 cycle after accept, writes land at the accept edge.
// Backpressure: one transfer per cycle; losing channels see req_ready=0 and must hold their request.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    slave modport: per-channel requests in, one-hot grant and tagged read response out
module memory_n_to_1_arbiter #(
  parameter int WIDTH          = 32,
  parameter int NUM_CH         = 4,
  parameter int CH_DEPTH       = 14,
  parameter int CH_DEPTH_LOG   = $clog2(CH_DEPTH),
  parameter int CH_LOG         = $clog2(NUM_CH),
  parameter int FULL_DEPTH     = NUM_CH * CH_DEPTH,
  parameter int FULL_DEPTH_LOG = $clog2(FULL_DEPTH),
  parameter int RR_MODE        = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  memory_n_to_1_arbiter_if.slave  bus
);

  // One extra bit so a window of exactly 2**CH_DEPTH_LOG words never flags out-of-range.
  localparam logic [CH_DEPTH_LOG:0] CH_DEPTH_W = (CH_DEPTH_LOG + 1)'(CH_DEPTH);
  localparam logic [CH_LOG-1:0]     LAST_CH    = CH_LOG'(NUM_CH - 1);

  logic [CH_LOG-1:0]         last_ptr;
  logic [CH_LOG-1:0]         grant_idx;
  logic [CH_LOG-1:0]         cand;
  logic                      found;
  logic [NUM_CH-1:0]         grant;

  logic                      sel_we;
  logic [CH_DEPTH_LOG-1:0]   sel_addr;
  logic [WIDTH-1:0]          sel_din;
  logic                      oob;

  logic                      mem_we;
  logic [FULL_DEPTH_LOG-1:0] mem_addr;
  logic [WIDTH-1:0]          mem_din;
  logic [WIDTH-1:0]          mem_q;
  logic [WIDTH-1:0]          mem [FULL_DEPTH];

  logic                      rsp_v;
  logic [CH_LOG-1:0]         rsp_ch;
  logic                      rsp_oob;
  logic                      err_oob_q;

  // Window base addresses, one constant per channel.
  logic [FULL_DEPTH_LOG-1:0] base_tbl [NUM_CH];
  for (genvar g = 0; g < NUM_CH; g++) begin : g_base
    assign base_tbl[g] = FULL_DEPTH_LOG'(g * CH_DEPTH);
  end

  // Search order: round-robin starts just after the last granted channel,
  // fixed priority always starts at channel 0. First valid candidate wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (RR_MODE != 0) begin
        cand = CH_LOG'((int'(last_ptr) + 1 + k) % NUM_CH);
      end else begin
        cand = CH_LOG'(k);
      end
      if (!found && bus.req_valid[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end
    grant[grant_idx] = found;
  end

  assign bus.req_ready = grant;

  // Granted channel's request fields.
  assign sel_we   = bus.req_we[grant_idx];
  assign sel_addr = bus.req_addr[int'(grant_idx) * CH_DEPTH_LOG +: CH_DEPTH_LOG];
  assign sel_din  = bus.req_din[int'(grant_idx) * WIDTH +: WIDTH];
  assign oob      = {1'b0, sel_addr} >= CH_DEPTH_W;

  // Idle and out-of-window cycles park the memory at address 0 with writes off,
  // so a stray address can never reach a neighbouring window.
  assign mem_we   = found & sel_we & ~oob;
  assign mem_addr = (found && !oob) ? FULL_DEPTH_LOG'(sel_addr) + base_tbl[grant_idx] : '0;
  assign mem_din  = found ? sel_din : '0;

  // Shared single-port memory with registered read.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_din;
    end
    mem_q <= mem[mem_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_ptr  <= LAST_CH;
      rsp_v     <= 1'b0;
      rsp_ch    <= '0;
      rsp_oob   <= 1'b0;
      err_oob_q <= 1'b0;
    end else begin
      if (found) begin
        last_ptr <= grant_idx;
      end
      rsp_v     <= found & ~sel_we;
      rsp_oob   <= found & ~sel_we & oob;
      err_oob_q <= found & oob;
      if (found && !sel_we) begin
        rsp_ch <= grant_idx;
      end
    end
  end

  assign bus.rd_valid = rsp_v;
  assign bus.rd_ch    = rsp_ch;
  assign bus.rd_data  = (rsp_v && !rsp_oob) ? mem_q : '0;
  assign bus.err_oob  = err_oob_q;

endmodule

// File: doc/memory_n_to_1_arbiter.md
# memory_n_to_1_arbiter

Parametrised N-channel front end for one shared single-port memory (`single_port_mem`, 1-cycle registered read). Each channel sees a private window of `CH_DEPTH` words at base `i*CH_DEPTH`. Requests arrive over valid/ready handshakes and are arbitrated one per cycle, by round-robin or fixed priority. Read data returns tagged with the channel index. It sits between the top-controller sub-units and their shared scratch memory, replacing hard-wired 4-way priority muxing.

## Interface
- `WIDTH`, 32, data word width.
- `NUM_CH`, 4, number of channels (2..16).
- `CH_DEPTH`, 14, words per channel window.
- `CH_DEPTH_LOG`, `CLOG2(CH_DEPTH)`, per-channel address width.
- `CH_LOG`, `CLOG2(NUM_CH)`, channel index width.
- `FULL_DEPTH`, `NUM_CH*CH_DEPTH`, physical memory depth; `FULL_DEPTH_LOG` = `CLOG2(FULL_DEPTH)`.
- `RR_MODE`, 1, 1 = round-robin, 0 = fixed priority (channel 0 highest).

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NUM_CH  per-channel request valid.
- `req_we`  in  NUM_CH  1 = write, 0 = read.
- `req_addr`  in  NUM_CH*CH_DEPTH_LOG  channel-local address; channel i occupies slice i.
- `req_din`  in  NUM_CH*WIDTH  write data; channel i occupies slice i.
- `req_ready`  out  NUM_CH  one-hot grant; transfer occurs when `req_valid[i] & req_ready[i]`.
- `rd_valid`  out  1  read response valid.
- `rd_ch`  out  CH_LOG  channel the response belongs to.
- `rd_data`  out  WIDTH  read data; 0 whenever `rd_valid` = 0 or the read was out of range.
- `err_oob`  out  1  one-cycle pulse: the transfer accepted in the previous cycle had `req_addr >= CH_DEPTH`.

## Operation
- **Grant.** `req_ready` is combinational from `req_valid` and the arbitration pointer.
  - At most one bit is set.
  - If `req_valid` = 0, `req_ready` = 0.
  - Reads and writes compete equally; there is no write-over-read preference.
- **Fixed mode** (`RR_MODE` = 0): the lowest-index valid channel wins.
- **Round-robin mode** (`RR_MODE` = 1):
  - `last_ptr` holds the last granted channel.
  - The search starts at `last_ptr+1` and wraps modulo `NUM_CH`.
  - `last_ptr` updates only on an accepted transfer.
- **Address.** Physical address = `{zero-ext req_addr} + i*CH_DEPTH`, computed at `FULL_DEPTH_LOG` bits. Base constants are generated from the parameters; there is no per-channel parameter list.
- **In-range transfer.** Memory `wr_en` = `req_we` of the granted channel; data and address come from the granted slice.
- **Out-of-range transfer** (`req_addr >= CH_DEPTH`):
  - The transfer is still accepted.
  - Memory `wr_en` is forced to 0.
  - `err_oob` pulses next cycle.
  - A read still returns `rd_valid` with `rd_data` = 0.
- **Response pipeline.** Registers `rsp_v`, `rsp_ch`, `rsp_oob` capture the accepted read.
  - `rd_valid` = `rsp_v`.
  - `rd_data` = `(rsp_v & ~rsp_oob) ? mem_q : 0`.
- **Writes** produce no response.
- **Idle cycle.** Memory address is driven to 0 with `wr_en` = 0. This prevents stray writes.

## Timing
- Reset values:
  - `last_ptr` = `NUM_CH-1`, so channel 0 is first in round-robin.
  - `rsp_v`, `rsp_ch`, `rsp_oob`, `err_oob` = 0.
  - Therefore `rd_valid` = 0, `rd_ch` = 0, `rd_data` = 0.
- Grant latency is 0 cycles: a lone request in cycle T is accepted in T.
- Read latency: accepted in T, so `rd_valid`/`rd_ch`/`rd_data` are valid in T+1 for exactly one cycle.
- Write: accepted in T, memory updated at the T edge. A read of the same address accepted in T+1 returns the new data in T+2.
- Throughput is one transfer per cycle. Back-to-back reads from different channels give consecutive `rd_valid` cycles, each with its own `rd_ch`.
- A channel holding `req_valid` while not granted must keep `req_we`/`req_addr`/`req_din` stable. The block does not check this.
- Reset asserted mid-operation:
  - All registers clear asynchronously.
  - A read accepted in the cycle before reset yields no response.
  - Grants resume from channel 0 after `rst_n` rises.
- `NUM_CH` = 2 with round-robin must alternate strictly under continuous contention.

## Test plan
- **Reset.** Hold `rst_n` = 0 with all `req_valid` = 1 → outputs 0. After release, the first grant goes to ch0 (`req_ready` = 4'b0001).
- **Window isolation.** Each ch i writes `0xA000_0000+i` to local addr 13, then reads it back → `rd_valid` one cycle after each read accept, `rd_ch` = i, `rd_data` = `0xA000_0000+i`. Physical addresses written are 13, 27, 41, 55.
- **Round-robin fairness.** All 4 channels hold reads for 8 cycles with `RR_MODE` = 1 → grant order 0,1,2,3,0,1,2,3 and 8 consecutive `rd_valid` with matching `rd_ch`. With `RR_MODE` = 0 → ch0 granted all 8 cycles.
- **Out-of-range access.** Ch2 writes addr 14 with data `0xFFFF_FFFF` → `err_oob` pulses one cycle; physical word 42 (ch3 addr 0) is unchanged on readback. Ch2 read of addr 15 → `rd_valid` = 1, `rd_ch` = 2, `rd_data` = 0, `err_oob` = 1.
- **Write-then-read.** Ch1 writes `0x1234` to addr 5 in T; ch1 reads addr 5 in T+1 → `rd_data` = `0x1234` in T+2.
- **Reset mid-operation.** Ch3 read accepted in T, `rst_n` = 0 during T+1 → no `rd_valid` pulse; `rd_data` = 0. After release, the next grant goes to ch0.
